// File: rtl/hs32_ex_operand.sv
// Execute-stage operand/issue register for hs32: shifts operand B, evaluates the
// condition code against ALU flags, and issues or annuls the op toward the ALU.
package hs32_pkg;
    typedef struct packed {
        logic [3:0] op;
        logic       fwe;
        logic [2:0] rd;
    } hs32_aluctl;
endpackage

module hs32_ex_operand
    import hs32_pkg::*;
#(
    parameter int CNTW = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [31:0]      a_i,
    input  logic [31:0]      b_i,
    input  logic [4:0]       shamt_i,
    input  logic [1:0]       shtype_i,
    input  logic [3:0]       cond_i,
    input  hs32_aluctl       ctl_i,
    input  logic [3:0]       flags_i,
    input  logic             flush_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [31:0]      a_o,
    output logic [31:0]      b_o,
    output hs32_aluctl       ctl_o,
    output logic [CNTW-1:0]  annul_cnt_o
);

    logic            valid_q, valid_d;
    logic [31:0]     a_q, a_d;
    logic [31:0]     b_q, b_d;
    hs32_aluctl      ctl_q, ctl_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic [31:0] bShifted;
    logic [63:0] rotWide;
    logic        condPass;
    logic        hazard;
    logic        accept;
    logic        flagN, flagZ, flagC, flagV;

    assign {flagN, flagZ, flagC, flagV} = flags_i;

    // Rotation is taken from the low half of B concatenated with itself.
    always_comb begin
        rotWide  = {b_i, b_i} >> shamt_i;
        bShifted = b_i;
        unique case (shtype_i)
            2'b00: bShifted = b_i << shamt_i;
            2'b01: bShifted = b_i >> shamt_i;
            2'b10: bShifted = $unsigned($signed(b_i) >>> shamt_i);
            2'b11: bShifted = rotWide[31:0];
            default: bShifted = b_i;
        endcase
    end

    always_comb begin
        condPass = 1'b0;
        unique case (cond_i)
            4'd0:  condPass = 1'b1;
            4'd1:  condPass = flagZ;
            4'd2:  condPass = !flagZ;
            4'd3:  condPass = flagC;
            4'd4:  condPass = !flagC;
            4'd5:  condPass = flagN;
            4'd6:  condPass = !flagN;
            4'd7:  condPass = flagV;
            4'd8:  condPass = !flagV;
            4'd9:  condPass = flagC & !flagZ;
            4'd10: condPass = !flagC | flagZ;
            4'd11: condPass = (flagN == flagV);
            4'd12: condPass = (flagN != flagV);
            4'd13: condPass = !flagZ & (flagN == flagV);
            4'd14: condPass = flagZ | (flagN != flagV);
            4'd15: condPass = 1'b0;
            default: condPass = 1'b0;
        endcase
    end

    // A held flag-writer makes flags_i stale for any conditional op behind it.
    assign hazard  = valid_q & ctl_q.fwe & (cond_i != 4'd0) & (cond_i != 4'd15);
    assign ready_o = !hazard & (!valid_q | ready_i);
    assign accept  = valid_i & ready_o;

    always_comb begin
        valid_d = valid_q;
        a_d     = a_q;
        b_d     = b_q;
        ctl_d   = ctl_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (accept && condPass) begin
            valid_d = 1'b1;
            a_d     = a_i;
            b_d     = bShifted;
            ctl_d   = ctl_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
        if (accept && !condPass && !flush_i && (cnt_q != {CNTW{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            ctl_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ctl_q   <= ctl_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid_o     = valid_q;
    assign a_o         = a_q;
    assign b_o         = b_q;
    assign ctl_o       = ctl_q;
    assign annul_cnt_o = cnt_q;

endmodule

// File: tb/tb_hs32_ex_operand.sv
// Testbench for hs32_ex_operand: directed scenarios followed by random traffic,
// all checked against a cycle-level behavioural model of the issue register.
module tb_hs32_ex_operand;
    import hs32_pkg::*;

    localparam int CNTW = 16;
    localparam logic [1:0] LSL = 2'b00, LSR = 2'b01, ASR = 2'b10, ROR = 2'b11;
    localparam logic [3:0] AL = 4'd0, EQ = 4'd1, NE = 4'd2;

    logic            clk = 1'b0;
    logic            reset;
    logic            valid_i;
    logic            ready_o;
    logic [31:0]     a_i;
    logic [31:0]     b_i;
    logic [4:0]      shamt_i;
    logic [1:0]      shtype_i;
    logic [3:0]      cond_i;
    hs32_aluctl      ctl_i;
    logic [3:0]      flags_i;
    logic            flush_i;
    logic            valid_o;
    logic            ready_i;
    logic [31:0]     a_o;
    logic [31:0]     b_o;
    hs32_aluctl      ctl_o;
    logic [CNTW-1:0] annul_cnt_o;

    int checks = 0;
    int failures = 0;

    logic       mValid;
    logic [31:0] mA, mB;
    hs32_aluctl mCtl;
    int         mCnt;
    logic       lastReady;

    hs32_aluctl ctlPlain = '{op: 4'h2, fwe: 1'b0, rd: 3'd1};
    hs32_aluctl ctlFlags = '{op: 4'h5, fwe: 1'b1, rd: 3'd3};

    hs32_ex_operand #(.CNTW(CNTW)) dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o),
        .a_i(a_i), .b_i(b_i), .shamt_i(shamt_i), .shtype_i(shtype_i),
        .cond_i(cond_i), .ctl_i(ctl_i), .flags_i(flags_i), .flush_i(flush_i),
        .valid_o(valid_o), .ready_i(ready_i), .a_o(a_o), .b_o(b_o),
        .ctl_o(ctl_o), .annul_cnt_o(annul_cnt_o)
    );

    always #5 clk = ~clk;

    // Shift done one bit position at a time, the way the shift types are defined.
    function automatic logic [31:0] shiftRef(input logic [31:0] b, input int s, input logic [1:0] t);
        logic [31:0] r;
        r = b;
        for (int i = 0; i < s; i++) begin
            case (t)
                LSL: r = r * 2;
                LSR: r = r / 2;
                ASR: r = (r / 2) | (b[31] ? 32'h8000_0000 : 32'h0);
                default: r = (r / 2) | ((r % 2 == 1) ? 32'h8000_0000 : 32'h0);
            endcase
        end
        return r;
    endfunction

    function automatic logic condRef(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:  return 1'b1;
            4'd1:  return z;
            4'd2:  return !z;
            4'd3:  return cy;
            4'd4:  return !cy;
            4'd5:  return n;
            4'd6:  return !n;
            4'd7:  return v;
            4'd8:  return !v;
            4'd9:  return cy && !z;
            4'd10: return !cy || z;
            4'd11: return n == v;
            4'd12: return n != v;
            4'd13: return !z && (n == v);
            4'd14: return z || (n != v);
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        chk({tag, "_valid"}, 32'(valid_o), 32'(mValid));
        chk({tag, "_a"}, a_o, mA);
        chk({tag, "_b"}, b_o, mB);
        chk({tag, "_ctl"}, 32'(ctl_o), 32'(mCtl));
        chk({tag, "_cnt"}, 32'(annul_cnt_o), 32'(mCnt));
    endtask

    task automatic modelReset();
        mValid = 1'b0;
        mA = '0;
        mB = '0;
        mCtl = '0;
        mCnt = 0;
    endtask

    // One clock of traffic: drive, check ready, advance the model, check registers.
    task automatic applyStimulus(input string tag, input logic vi, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] sh, input logic [1:0] st,
                                 input logic [3:0] cond, input hs32_aluctl ctl,
                                 input logic [3:0] flags, input logic fl, input logic rdy);
        logic expReady, stale, pass, acc;
        valid_i = vi; a_i = a; b_i = b; shamt_i = sh; shtype_i = st;
        cond_i = cond; ctl_i = ctl; flags_i = flags; flush_i = fl; ready_i = rdy;
        #1;
        stale = mValid && mCtl.fwe && cond != AL && cond != 4'd15;
        expReady = !stale && (!mValid || rdy);
        lastReady = ready_o;
        chk({tag, "_ready"}, 32'(ready_o), 32'(expReady));
        pass = condRef(cond, flags);
        acc = vi && expReady;
        if (fl) begin
            mValid = 1'b0;
        end else if (acc && pass) begin
            mValid = 1'b1;
            mA = a;
            mB = shiftRef(b, int'(sh), st);
            mCtl = ctl;
        end else if (rdy) begin
            mValid = 1'b0;
        end
        if (acc && !pass && !fl && mCnt < (1 << CNTW) - 1) mCnt++;
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        reset = 1'b0;
        valid_i = 0; a_i = 0; b_i = 0; shamt_i = 0; shtype_i = 0;
        cond_i = 0; ctl_i = '0; flags_i = 0; flush_i = 0; ready_i = 0;
        modelReset();
        #3;
        checkOutput("reset");
        @(negedge clk);
        reset = 1'b1;

        $display("[TB] shifter");
        applyStimulus("lsl", 1, 32'h1, 32'h8000_0001, 5'd4, LSL, AL, ctlPlain, 4'h0, 0, 1);
        chk("shift_lsl", b_o, 32'h0000_0010);
        applyStimulus("lsr", 1, 32'h2, 32'h8000_0001, 5'd4, LSR, AL, ctlPlain, 4'h0, 0, 1);
        chk("shift_lsr", b_o, 32'h0800_0000);
        applyStimulus("asr", 1, 32'h3, 32'h8000_0001, 5'd4, ASR, AL, ctlPlain, 4'h0, 0, 1);
        chk("shift_asr", b_o, 32'hF800_0000);
        applyStimulus("ror", 1, 32'h4, 32'h8000_0001, 5'd4, ROR, AL, ctlPlain, 4'h0, 0, 1);
        chk("shift_ror", b_o, 32'h1800_0000);
        applyStimulus("asr0", 1, 32'h5, 32'h8000_0001, 5'd0, ASR, AL, ctlPlain, 4'h0, 0, 1);
        chk("shift_asr0", b_o, 32'h8000_0001);

        $display("[TB] basic issue");
        applyStimulus("basic", 1, 32'd5, 32'd3, 5'd0, LSL, AL, ctlFlags, 4'h0, 0, 1);
        chk("basic_a", a_o, 32'd5);
        chk("basic_ctl", 32'(ctl_o), 32'(ctlFlags));
        applyStimulus("drain", 0, 32'd0, 32'd0, 5'd0, LSL, AL, ctlPlain, 4'h0, 0, 1);

        $display("[TB] annul");
        applyStimulus("annul", 1, 32'd7, 32'd7, 5'd0, LSL, NE, ctlPlain, 4'b0100, 0, 1);
        chk("annul_ready", 32'(lastReady), 32'd1);
        chk("annul_cnt", 32'(annul_cnt_o), 32'd1);
        applyStimulus("eq_pass", 1, 32'd8, 32'd8, 5'd0, LSL, EQ, ctlPlain, 4'b0100, 0, 1);
        chk("eq_valid", 32'(valid_o), 32'd1);

        $display("[TB] flag hazard");
        applyStimulus("fwe_op", 1, 32'h10, 32'h11, 5'd0, LSL, AL, ctlFlags, 4'h0, 0, 1);
        applyStimulus("hazard", 1, 32'h20, 32'h21, 5'd0, LSL, EQ, ctlPlain, 4'b0100, 0, 1);
        chk("hazard_ready", 32'(lastReady), 32'd0);
        applyStimulus("post_haz", 1, 32'h20, 32'h21, 5'd0, LSL, EQ, ctlPlain, 4'b0100, 0, 1);
        chk("post_haz_a", a_o, 32'h20);

        $display("[TB] backpressure");
        for (int i = 0; i < 3; i++) begin
            applyStimulus("stall", 1, 32'h30 + i, 32'h31, 5'd0, LSL, AL, ctlPlain, 4'h0, 0, 0);
            chk("stall_ready", 32'(lastReady), 32'd0);
            chk("stall_hold_a", a_o, 32'h20);
        end
        applyStimulus("release", 1, 32'h99, 32'h9A, 5'd0, LSL, AL, ctlPlain, 4'h0, 0, 1);
        chk("release_a", a_o, 32'h99);

        $display("[TB] flush");
        applyStimulus("flush_pass", 1, 32'h55, 32'h56, 5'd0, LSL, AL, ctlPlain, 4'h0, 1, 1);
        chk("flush_valid", 32'(valid_o), 32'd0);
        applyStimulus("flush_fail", 1, 32'h57, 32'h58, 5'd0, LSL, NE, ctlPlain, 4'b0100, 1, 1);
        chk("flush_cnt", 32'(annul_cnt_o), 32'd1);

        $display("[TB] async reset");
        applyStimulus("pre_rst", 1, 32'h77, 32'h78, 5'd1, LSL, AL, ctlFlags, 4'h0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        modelReset();
        checkOutput("async_rst");
        valid_i = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        applyStimulus("post_rst", 1, 32'h42, 32'h43, 5'd2, ROR, AL, ctlPlain, 4'h0, 0, 1);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            hs32_aluctl rc;
            rc = hs32_aluctl'($urandom_range(255, 0));
            applyStimulus("rand", ($urandom_range(3, 0) != 0), $urandom, $urandom,
                          5'($urandom_range(31, 0)), 2'($urandom_range(3, 0)),
                          4'($urandom_range(15, 0)), rc, 4'($urandom_range(15, 0)),
                          ($urandom_range(15, 0) == 0), ($urandom_range(2, 0) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
